t1_sim_watchdog: RTL and testbench
==================================

T1_SIM_WATCHDOG -- requirements
Module: t1_sim_watchdog

Interface
REQ-001 SHALL have parameter DEFAULT_TIMEOUT, default 1000000: timeout limit in cycles loaded at reset.
REQ-002 SHALL have parameter OUTSTANDING_WIDTH, default 8: width of the in-flight instruction counter.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port cfg_timeout_valid, input, 1: load strobe for cfg_timeout.
REQ-006 SHALL have port cfg_timeout, input, 64: max cycles between two retires; 0 disables the timeout.
REQ-007 SHALL have port issue_valid, input, 1: one vector instruction issued this cycle.
REQ-008 SHALL have port retire_valid, input, 1: one vector instruction retired this cycle.
REQ-009 SHALL have port host_done, input, 1: level; host side has issued its last instruction.
REQ-010 SHALL have port status, output, 8: poll result: 0 continue, 255 success, any other value is an error code.
REQ-011 SHALL have port outstanding, output, OUTSTANDING_WIDTH: current in-flight count.
REQ-012 SHALL have port idle_cycles, output, 64: cycles since the last retire or timer clear.

Function
REQ-013 SHALL implement FSM states RUN, DRAIN, DONE, FAIL; DONE and FAIL are sticky until reset.
REQ-014 SHALL drive status from registered state only: RUN/DRAIN -> 0, DONE -> 255, FAIL -> latched error code; the response is 1 cycle after the causing edge.
REQ-015 SHALL update outstanding per cycle: +1 on issue only, -1 on retire only, unchanged on both or neither.
REQ-016 SHALL enter FAIL code 2 (underflow) on retire_valid without issue_valid while outstanding == 0; outstanding then holds.
REQ-017 SHALL enter FAIL code 3 (overflow) on issue_valid without retire_valid while outstanding == all-ones; outstanding then holds.
REQ-018 SHALL clear idle_cycles to 0 on any retire_valid or cfg_timeout_valid; otherwise it increments by 1 per cycle in RUN/DRAIN and saturates at all-ones.
REQ-019 SHALL enter FAIL code 1 (timeout) when the timeout limit != 0 and idle_cycles == limit - 1 with no clearing event in that cycle; status therefore reads 1 on the cycle after the limit-th idle cycle.
REQ-020 SHALL load the timeout limit from cfg_timeout on cfg_timeout_valid in any non-sticky state; the new limit applies from the next cycle.
REQ-021 SHALL transition RUN -> DRAIN when host_done = 1.
REQ-022 SHALL enter FAIL code 4 (issue after done) on issue_valid while in DRAIN.
REQ-023 SHALL transition DRAIN -> DONE when the next-cycle outstanding value is 0 and no error condition occurs.
REQ-024 SHALL transition RUN -> DONE directly when host_done = 1 and the next outstanding is 0.
REQ-025 SHALL resolve errors in the same cycle by priority 2 > 3 > 4 > 1; an error outranks a DONE transition.
REQ-026 SHALL freeze outstanding, idle_cycles and the limit in DONE and FAIL, and ignore all inputs there.

Reset
REQ-027 SHALL, on reset assertion, asynchronously force state = RUN, status = 0, outstanding = 0, idle_cycles = 0 and limit = DEFAULT_TIMEOUT, including mid-operation or from DONE/FAIL.
REQ-028 SHALL begin normal counting on the first rising edge after reset deasserts.

Verification
REQ-029 SHALL be verified by: 3 issues, 3 retires, then host_done -> status = 255 one cycle after the last retire, and outstanding = 0.
REQ-030 SHALL be verified by: cfg_timeout = 5, 1 issue, no retire -> status = 0 through idle_cycles = 4, then status = 1 and stays 1.
REQ-031 SHALL be verified by: a retire with outstanding = 0 -> status = 2 next cycle; a simultaneous issue and retire at 0 -> no error, outstanding = 0.
REQ-032 SHALL be verified by: OUTSTANDING_WIDTH = 2, 4 issues with no retire -> status = 3 on the 4th, outstanding = 3.
REQ-033 SHALL be verified by: host_done with outstanding = 2, then an issue -> status = 4; reset asserted -> status = 0 and outstanding = 0 immediately, without waiting for a clock edge.
REQ-034 SHALL be verified by: cfg_timeout = 0, 10^4 idle cycles -> status remains 0 and idle_cycles = 10000.

Source files
------------

// File: rtl/t1_sim_watchdog.sv
// Simulation watchdog: tracks in-flight vector instructions and retire gaps, and reports
// continue / success / error-code status to a polling host.
module t1_sim_watchdog #(
   parameter logic [63:0] DEFAULT_TIMEOUT   = 64'd1000000,
   parameter int unsigned OUTSTANDING_WIDTH = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         cfg_timeout_valid,
   input  logic [63:0]                  cfg_timeout,
   input  logic                         issue_valid,
   input  logic                         retire_valid,
   input  logic                         host_done,
   output logic [7:0]                   status,
   output logic [OUTSTANDING_WIDTH-1:0] outstanding,
   output logic [63:0]                  idle_cycles
);

   typedef enum logic [1:0] {StRun, StDrain, StDone, StFail} state_e;

   localparam logic [OUTSTANDING_WIDTH-1:0] OutMax = '1;
   localparam logic [OUTSTANDING_WIDTH-1:0] OutOne = OUTSTANDING_WIDTH'(1);

   localparam logic [7:0] CodeTimeout   = 8'd1;
   localparam logic [7:0] CodeUnderflow = 8'd2;
   localparam logic [7:0] CodeOverflow  = 8'd3;
   localparam logic [7:0] CodeLateIssue = 8'd4;
   localparam logic [7:0] CodeSuccess   = 8'd255;

   state_e                         state_q, state_d;
   logic [7:0]                     status_q, status_d;
   logic [OUTSTANDING_WIDTH-1:0]   out_q, out_d;
   logic [63:0]                    idle_q, idle_d;
   logic [63:0]                    limit_q, limit_d;

   logic       inc, dec, underflow, overflow, late_issue, timeout, clear;
   logic [7:0] err_code;

   always_comb begin
      inc        = issue_valid & ~retire_valid;
      dec        = retire_valid & ~issue_valid;
      underflow  = dec && (out_q == '0);
      overflow   = inc && (out_q == OutMax);
      late_issue = (state_q == StDrain) && issue_valid;
      clear      = retire_valid | cfg_timeout_valid;
      timeout    = (limit_q != 64'd0) && (idle_q == limit_q - 64'd1) && !clear;

      out_d = out_q;
      if (inc && !overflow) begin
         out_d = out_q + OutOne;
      end else if (dec && !underflow) begin
         out_d = out_q - OutOne;
      end

      if (clear) begin
         idle_d = 64'd0;
      end else if (&idle_q) begin
         idle_d = idle_q;
      end else begin
         idle_d = idle_q + 64'd1;
      end

      limit_d = cfg_timeout_valid ? cfg_timeout : limit_q;

      // Fixed priority when several errors coincide in one cycle.
      if (underflow) begin
         err_code = CodeUnderflow;
      end else if (overflow) begin
         err_code = CodeOverflow;
      end else if (late_issue) begin
         err_code = CodeLateIssue;
      end else if (timeout) begin
         err_code = CodeTimeout;
      end else begin
         err_code = 8'd0;
      end

      state_d = state_q;
      if (err_code != 8'd0) begin
         state_d = StFail;
      end else if (state_q == StRun && host_done) begin
         state_d = (out_d == '0) ? StDone : StDrain;
      end else if (state_q == StDrain && out_d == '0) begin
         state_d = StDone;
      end

      unique case (state_d)
         StFail:  status_d = err_code;
         StDone:  status_d = CodeSuccess;
         default: status_d = 8'd0;
      endcase
   end

   // DONE and FAIL are sticky: nothing below updates once either is reached.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= StRun;
         status_q <= 8'd0;
         out_q    <= '0;
         idle_q   <= 64'd0;
         limit_q  <= DEFAULT_TIMEOUT;
      end else if (state_q == StRun || state_q == StDrain) begin
         state_q  <= state_d;
         status_q <= status_d;
         out_q    <= out_d;
         idle_q   <= idle_d;
         limit_q  <= limit_d;
      end
   end

   assign status      = status_q;
   assign outstanding = out_q;
   assign idle_cycles = idle_q;

endmodule

// File: tb/tb_t1_sim_watchdog.sv
// Directed bench for t1_sim_watchdog: expectations are queued as stimulus is applied and
// checked after the following clock edge (or immediately for asynchronous reset).
module tb_t1_sim_watchdog;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cfg_timeout_valid;
   logic [63:0] cfg_timeout;
   logic        issue_valid;
   logic        retire_valid;
   logic        host_done;

   logic [7:0]  status;
   logic [7:0]  outstanding;
   logic [63:0] idle_cycles;
   logic [7:0]  status2;
   logic [1:0]  outstanding2;
   logic [63:0] idle_cycles2;

   int n_assert = 0;
   int n_fail   = 0;

   localparam int KStatus = 0;
   localparam int KOut    = 1;
   localparam int KIdle   = 2;
   localparam int KStat2  = 3;
   localparam int KOut2   = 4;

   typedef struct {
      string       tag;
      int          kind;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];

   t1_sim_watchdog dut (
      .clock             (clock),
      .reset             (reset),
      .cfg_timeout_valid (cfg_timeout_valid),
      .cfg_timeout       (cfg_timeout),
      .issue_valid       (issue_valid),
      .retire_valid      (retire_valid),
      .host_done         (host_done),
      .status            (status),
      .outstanding       (outstanding),
      .idle_cycles       (idle_cycles)
   );

   t1_sim_watchdog #(.OUTSTANDING_WIDTH(2)) dut2 (
      .clock             (clock),
      .reset             (reset),
      .cfg_timeout_valid (cfg_timeout_valid),
      .cfg_timeout       (cfg_timeout),
      .issue_valid       (issue_valid),
      .retire_valid      (retire_valid),
      .host_done         (host_done),
      .status            (status2),
      .outstanding       (outstanding2),
      .idle_cycles       (idle_cycles2)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] observe(input int kind);
      case (kind)
         KStatus: return {56'd0, status};
         KOut:    return {56'd0, outstanding};
         KIdle:   return idle_cycles;
         KStat2:  return {56'd0, status2};
         default: return {62'd0, outstanding2};
      endcase
   endfunction

   task automatic push_exp(input string tag, input int kind, input logic [63:0] val);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic check_all();
      exp_t        e;
      logic [63:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.kind);
         n_assert++;
         assert (obs === e.val)
         else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic drive(input logic iv, input logic rv, input logic hd);
      issue_valid  = iv;
      retire_valid = rv;
      host_done    = hd;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0);
      cfg_timeout_valid = 1'b0;
      cfg_timeout       = 64'd0;
      reset             = 1'b1;
      #1;
      push_exp("rst_status", KStatus, 64'd0);
      push_exp("rst_out", KOut, 64'd0);
      push_exp("rst_idle", KIdle, 64'd0);
      push_exp("rst_out2", KOut2, 64'd0);
      check_all();
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      do_reset();

      // 3 issues, 3 retires with host_done -> success after the last retire
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         push_exp("issue_out", KOut, 64'(i));
         push_exp("issue_status", KStatus, 64'd0);
         tick();
      end
      for (int i = 2; i >= 0; i--) begin
         drive(1'b0, 1'b1, 1'b1);
         push_exp("retire_out", KOut, 64'(i));
         push_exp("retire_status", KStatus, (i == 0) ? 64'd255 : 64'd0);
         push_exp("retire_idle", KIdle, 64'd0);
         tick();
      end
      drive(1'b1, 1'b0, 1'b0);
      push_exp("done_sticky_status", KStatus, 64'd255);
      push_exp("done_frozen_out", KOut, 64'd0);
      tick();

      // timeout of 5 cycles
      do_reset();
      cfg_timeout_valid = 1'b1;
      cfg_timeout       = 64'd5;
      drive(1'b1, 1'b0, 1'b0);
      push_exp("to_load_idle", KIdle, 64'd0);
      push_exp("to_load_out", KOut, 64'd1);
      tick();
      cfg_timeout_valid = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         push_exp("to_idle", KIdle, 64'(i));
         push_exp("to_status_run", KStatus, 64'd0);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         push_exp("to_status_fail", KStatus, 64'd1);
         tick();
      end

      // underflow, then simultaneous issue/retire at zero
      do_reset();
      drive(1'b0, 1'b1, 1'b0);
      push_exp("uf_status", KStatus, 64'd2);
      push_exp("uf_out", KOut, 64'd0);
      tick();
      drive(1'b1, 1'b0, 1'b0);
      push_exp("uf_sticky_status", KStatus, 64'd2);
      push_exp("uf_frozen_out", KOut, 64'd0);
      tick();
      do_reset();
      drive(1'b1, 1'b1, 1'b0);
      push_exp("both_status", KStatus, 64'd0);
      push_exp("both_out", KOut, 64'd0);
      tick();

      // overflow on the 2-bit instance
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         push_exp("ovf_status2", KStat2, (i == 4) ? 64'd3 : 64'd0);
         push_exp("ovf_out2", KOut2, (i == 4) ? 64'd3 : 64'(i));
         push_exp("ovf_wide_out", KOut, 64'(i));
         tick();
      end

      // issue after done, then asynchronous reset mid-cycle
      do_reset();
      drive(1'b1, 1'b0, 1'b0);
      tick();
      tick();
      drive(1'b0, 1'b0, 1'b1);
      push_exp("drain_status", KStatus, 64'd0);
      push_exp("drain_out", KOut, 64'd2);
      tick();
      drive(1'b1, 1'b0, 1'b1);
      push_exp("late_issue_status", KStatus, 64'd4);
      tick();
      drive(1'b0, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      push_exp("async_rst_status", KStatus, 64'd0);
      push_exp("async_rst_out", KOut, 64'd0);
      check_all();
      @(posedge clock);
      #1;
      reset = 1'b0;

      // timeout disabled, long idle run
      do_reset();
      cfg_timeout_valid = 1'b1;
      cfg_timeout       = 64'd0;
      push_exp("dis_load_idle", KIdle, 64'd0);
      tick();
      cfg_timeout_valid = 1'b0;
      repeat (9999) tick();
      push_exp("dis_idle", KIdle, 64'd10000);
      push_exp("dis_status", KStatus, 64'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
